// File: rtl/reg_writeback_pkg.sv
// Register-file constants shared by the writeback producer and the register file.
package reg_writeback_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] LINK_REG = 5'd31;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_writeback_link_fifo.sv
// Small FIFO with registered count; full/empty come from the count only, so a
// pop in the same cycle does not free a slot for a push.
module link_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/reg_writeback.sv
// MEM/WB register plus single-port arbitration between normal writeback and
// buffered JAL link writes to r31.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [ADDR_W-1:0] mem_nd,
  input  logic [DATA_W-1:0] mem_alu,
  input  logic [DATA_W-1:0] mem_load,
  input  logic              link_req,
  input  logic [DATA_W-1:0] link_data,
  output logic              WriteReg,
  output logic [ADDR_W-1:0] ND,
  output logic [DATA_W-1:0] DI,
  output logic              link_stall,
  output logic              link_pending
);
  logic              wb_valid_q, wb_regwrite_q;
  logic [ADDR_W-1:0] wb_nd_q;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              norm_wr;
  logic              link_full, link_empty;
  logic [DATA_W-1:0] link_head;

  assign wb_data_d = mem_memtoreg ? mem_load : mem_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_nd_q       <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q    <= mem_valid;
      wb_regwrite_q <= mem_regwrite;
      wb_nd_q       <= mem_nd;
      wb_data_q     <= wb_data_d;
    end
  end

  // An r0 write frees the port so a pending link entry can drain in that slot.
  assign norm_wr = wb_valid_q & wb_regwrite_q & (wb_nd_q != REG_ZERO);

  link_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_link_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (link_req),
    .push_data_i(link_data),
    .pop_i      (~norm_wr),
    .full_o     (link_full),
    .empty_o    (link_empty),
    .head_o     (link_head)
  );

  assign link_stall   = link_full;
  assign link_pending = ~link_empty;

  always_comb begin
    WriteReg = 1'b0;
    ND       = '0;
    DI       = '0;
    if (norm_wr) begin
      WriteReg = 1'b1;
      ND       = wb_nd_q;
      DI       = wb_data_q;
    end else if (!link_empty) begin
      WriteReg = 1'b1;
      ND       = LINK_REG;
      DI       = link_head;
    end
  end
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench: expected port writes are queued as stimulus is driven and
// checked in order by a monitor on the falling edge.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_regwrite, mem_memtoreg;
  logic [4:0]  mem_nd;
  logic [31:0] mem_alu, mem_load;
  logic        link_req;
  logic [31:0] link_data;
  logic        WriteReg;
  logic [4:0]  ND;
  logic [31:0] DI;
  logic        link_stall, link_pending;

  typedef struct packed {
    logic [4:0]  nd;
    logic [31:0] di;
  } wr_t;

  wr_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_r31 = '0;

  reg_writeback #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_nd(mem_nd), .mem_alu(mem_alu), .mem_load(mem_load),
    .link_req(link_req), .link_data(link_data),
    .WriteReg(WriteReg), .ND(ND), .DI(DI),
    .link_stall(link_stall), .link_pending(link_pending)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (WriteReg === 1'b1) begin
      wr_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got ND=%0d DI=%h, required no write", ND, DI);
      end else begin
        e = exp_q.pop_front();
        if (ND !== e.nd || DI !== e.di) begin
          fails++;
          $display("FAIL port_write: got ND=%0d DI=%h, required ND=%0d DI=%h", ND, DI, e.nd, e.di);
        end
      end
      if (ND === 5'd31) last_r31 = DI;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0;
    mem_nd = '0; mem_alu = '0; mem_load = '0;
    link_req = 0; link_data = '0;
  endtask

  task automatic drive_wr(input logic m2r, input logic [4:0] nd,
                          input logic [31:0] alu, input logic [31:0] ld);
    mem_valid = 1; mem_regwrite = 1; mem_memtoreg = m2r;
    mem_nd = nd; mem_alu = alu; mem_load = ld;
  endtask

  task automatic expect_wr(input logic [4:0] nd, input logic [31:0] di);
    wr_t e;
    e.nd = nd;
    e.di = di;
    exp_q.push_back(e);
  endtask

  task automatic settle(input string name);
    repeat (4) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drained: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    #1;
    tests++;
    if ({WriteReg, ND, DI, link_stall, link_pending} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got WE=%b ND=%0d DI=%h stall=%b pend=%b, required all 0",
               WriteReg, ND, DI, link_stall, link_pending);
    end
    step(); step();
    reset = 0;
    settle("reset");
  endtask

  task automatic test_alu();
    drive_wr(0, 5'd8, 32'h1234, 32'h5555);
    expect_wr(5'd8, 32'h1234);
    step();
    idle();
    settle("alu");
  endtask

  task automatic test_load_r0();
    drive_wr(1, 5'd9, 32'h1111, 32'hDEADBEEF);
    expect_wr(5'd9, 32'hDEADBEEF);
    step();
    drive_wr(1, 5'd0, 32'h1111, 32'hDEADBEEF);
    step();
    idle();
    settle("load_r0");
  endtask

  task automatic test_collision();
    drive_wr(0, 5'd5, 32'h55, 32'h0);
    link_req = 1; link_data = 32'h400;
    expect_wr(5'd5, 32'h55);
    expect_wr(5'd31, 32'h400);
    step();
    idle();
    tests++;
    if (link_pending !== 1'b1) begin
      fails++;
      $display("FAIL collision_pending_set: got %b, required 1", link_pending);
    end
    step();
    step();
    tests++;
    if (link_pending !== 1'b0) begin
      fails++;
      $display("FAIL collision_pending_clear: got %b, required 0", link_pending);
    end
    settle("collision");
  endtask

  task automatic test_full();
    logic [31:0] lv [3];
    int lk = 0;
    logic st;
    lv[0] = 32'h10; lv[1] = 32'h20; lv[2] = 32'h30;
    for (int i = 0; i < 5; i++) expect_wr(5'(i + 1), 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) expect_wr(5'd31, lv[i]);
    for (int c = 0; c < 20; c++) begin
      if (c >= 5 && lk == 3) break;
      if (c < 5) drive_wr(0, 5'(c + 1), 32'h100 + 32'(c), 32'h0);
      else begin
        mem_valid = 0; mem_regwrite = 0;
      end
      if (lk < 3) begin
        link_req = 1; link_data = lv[lk];
      end else begin
        link_req = 0;
      end
      if (c == 2) begin
        tests++;
        if (link_stall !== 1'b1) begin
          fails++;
          $display("FAIL full_stall: got %b, required 1", link_stall);
        end
      end
      st = link_stall;
      step();
      if (lk < 3 && !st) lk++;
    end
    idle();
    tests++;
    if (lk != 3) begin
      fails++;
      $display("FAIL full_accepts: got %0d links accepted, required 3", lk);
    end
    settle("full");
  endtask

  task automatic test_order_r31();
    drive_wr(0, 5'd31, 32'hAAAA, 32'h0);
    link_req = 1; link_data = 32'hBBBB;
    expect_wr(5'd31, 32'hAAAA);
    expect_wr(5'd31, 32'hBBBB);
    step();
    idle();
    settle("order");
    tests++;
    if (last_r31 !== 32'hBBBB) begin
      fails++;
      $display("FAIL order_final_r31: got %h, required 0000bbbb", last_r31);
    end
  endtask

  task automatic test_reset_mid();
    drive_wr(0, 5'd1, 32'h1, 32'h0);
    link_req = 1; link_data = 32'h77;
    expect_wr(5'd1, 32'h1);
    step();
    drive_wr(0, 5'd2, 32'h2, 32'h0);
    link_data = 32'h88;
    step();
    idle();
    tests++;
    if (link_stall !== 1'b1 || link_pending !== 1'b1) begin
      fails++;
      $display("FAIL midreset_filled: got stall=%b pend=%b, required 1 1", link_stall, link_pending);
    end
    #1;
    reset = 1;
    #1;
    tests++;
    if ({WriteReg, ND, DI, link_pending} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got WE=%b ND=%0d DI=%h pend=%b, required all 0",
               WriteReg, ND, DI, link_pending);
    end
    step();
    reset = 0;
    settle("midreset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_r0();
    test_collision();
    test_full();
    test_order_r31();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
